// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker: exhaustive sequential checker for a combinational
// Skolem-function block. The block realises the invertibility condition of
// signed (x << s) <= t.
// Every (s, t) pair is driven out and the returned witness x is captured.
// The checker then brute-forces whether any x satisfies the condition and
// judges the witness against that result.
// Optional feature: define SKSWEEP_STOP_ON_FAIL_EN to end the sweep at the
// first failing pair instead of running all pairs.
module skolem_sweep_checker #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   s_o,
  output logic [W-1:0]   t_o,
  input  logic [W-1:0]   x_i,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   pair_cnt,
  output logic [2*W:0]   inv_cnt,
  output logic [2*W:0]   fail_cnt,
  output logic [W-1:0]   fail_s,
  output logic [W-1:0]   fail_t
);

  localparam int unsigned CW = 2 * W + 1;
  localparam int unsigned IW = 2 * W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SEARCH,
    ST_JUDGE,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   xs_q, xs_d;
  logic           found_q, found_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [CW-1:0]  pair_q, pair_d;
  logic [CW-1:0]  inv_q, inv_d;
  logic [CW-1:0]  fcnt_q, fcnt_d;
  logic [W-1:0]   fail_s_q, fail_s_d;
  logic [W-1:0]   fail_t_q, fail_t_d;

  logic           judge_fail_c;
  logic           judge_stop_c;
  logic [IW-1:0]  idx_next_c;

  // cond(x,s,t): (x << s) truncated to W bits, signed <= t; s >= W shifts to 0
  function automatic logic cond_f(input logic [W-1:0] x,
                                  input logic [W-1:0] s,
                                  input logic [W-1:0] t);
    logic [W-1:0] sh;
    if (32'(s) >= W) begin
      sh = '0;
    end else begin
      sh = x << s;
    end
    return $signed(sh) <= $signed(t);
  endfunction

  // Next-state and datapath updates for the sweep FSM
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    t_d          = t_q;
    x_d          = x_q;
    xs_d         = xs_q;
    found_d      = found_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pair_d       = pair_q;
    inv_d        = inv_q;
    fcnt_d       = fcnt_q;
    fail_s_d     = fail_s_q;
    fail_t_d     = fail_t_q;
    judge_fail_c = found_q && !cond_f(x_q, s_q, t_q);
    judge_stop_c = ({s_q, t_q} == {IW{1'b1}});
`ifdef SKSWEEP_STOP_ON_FAIL_EN
    judge_stop_c = judge_stop_c || judge_fail_c;
`endif
    idx_next_c   = IW'({s_q, t_q} + IW'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pair_d   = '0;
          inv_d    = '0;
          fcnt_d   = '0;
          fail_s_d = '0;
          fail_t_d = '0;
          s_d      = '0;
          t_d      = '0;
          busy_d   = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        x_d     = x_i;
        xs_d    = '0;
        found_d = 1'b0;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        found_d = found_q | cond_f(xs_q, s_q, t_q);
        xs_d    = W'(xs_q + W'(1));
        if (xs_q == {W{1'b1}}) begin
          state_d = ST_JUDGE;
        end
      end
      ST_JUDGE: begin
        pair_d = CW'(pair_q + CW'(1));
        if (found_q) begin
          inv_d = CW'(inv_q + CW'(1));
        end
        if (judge_fail_c) begin
          fcnt_d   = CW'(fcnt_q + CW'(1));
          fail_s_d = s_q;
          fail_t_d = t_q;
        end
        if (judge_stop_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          {s_d, t_d} = idx_next_c;
          state_d    = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      t_q      <= '0;
      x_q      <= '0;
      xs_q     <= '0;
      found_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pair_q   <= '0;
      inv_q    <= '0;
      fcnt_q   <= '0;
      fail_s_q <= '0;
      fail_t_q <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      t_q      <= t_d;
      x_q      <= x_d;
      xs_q     <= xs_d;
      found_q  <= found_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pair_q   <= pair_d;
      inv_q    <= inv_d;
      fcnt_q   <= fcnt_d;
      fail_s_q <= fail_s_d;
      fail_t_q <= fail_t_d;
    end
  end

  assign s_o      = s_q;
  assign t_o      = t_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pair_cnt = pair_q;
  assign inv_cnt  = inv_q;
  assign fail_cnt = fcnt_q;
  assign fail_s   = fail_s_q;
  assign fail_t   = fail_t_q;

endmodule
